// File: rtl/test_stream_pkg.sv
// test_stream_pkg: shared types and constants for the bench stream sink.
//   sink_state_e : sink FSM states (IDLE, RUN, DONE)
//   sink_flags_t : sticky status flags reported by the sink
//   LFSR_SEED    : reset value of the backpressure LFSR
//   LFSR_TAPS    : Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
//   lfsr_step()  : one LFSR advance
package test_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sink_state_e;

  typedef struct packed {
    logic error;
    logic overrun;
    logic timeout;
  } sink_flags_t;

  localparam logic [31:0] LFSR_SEED = 32'hdeadbeef;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/test_lfsr32.sv
// test_lfsr32: 32-bit Galois LFSR, taps 32,22,2,1.
//   clk, rst : clock, async active-high reset (q <= SEED)
//   en       : advance one step this cycle
//   load     : synchronously load 'seed' (takes priority over en)
//   seed     : reload value; must be nonzero or the register locks up
//   q        : current state
module test_lfsr32
  import test_stream_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= SEED;
    else if (load) q <= seed;
    else if (en)   q <= lfsr_step(q);
  end

endmodule

// File: rtl/test_stream_sink.sv
// test_stream_sink: val/rdy stream sink that checks DUT output messages
// against a preloaded table of expected values.
//
// Optional feature macro: TEST_STREAM_SINK_RANDOM_DELAY_EN
//   When defined, rdy is throttled by an LFSR-driven delay counter (0..p_max_delay
//   idle cycles loaded on start and after every transfer). When undefined,
//   rdy = (state == RUN).
//
// Ports:
//   clk, rst       : clock (rising edge), async active-high reset
//   load_en/addr/data : synchronous write port of the expected-message table
//   start          : one-cycle pulse, begins a check run (ignored in RUN)
//   num_msgs       : number of messages to expect, sampled on start, clamped
//   msg, val, rdy  : stream input from the DUT
//   done           : run complete (all messages consumed, or timeout)
//   error          : sticky any-mismatch / overrun / timeout
//   err_count      : mismatch count, saturating
//   first_err_idx  : index of the first mismatching message
//   overrun        : sticky, val seen while DONE
//   timeout        : sticky, p_timeout consecutive RUN cycles with no transfer
module test_stream_sink
  import test_stream_pkg::*;
#(
  parameter int p_msg_nbits = 32,
  parameter int p_num_msgs  = 16,
  parameter int p_timeout   = 1000,
  parameter int p_max_delay = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_en,
  input  logic [$clog2(p_num_msgs)-1:0] load_addr,
  input  logic [p_msg_nbits-1:0]        load_data,
  input  logic                          start,
  input  logic [$clog2(p_num_msgs):0]   num_msgs,
  input  logic [p_msg_nbits-1:0]        msg,
  input  logic                          val,
  output logic                          rdy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(p_num_msgs):0]   err_count,
  output logic [$clog2(p_num_msgs)-1:0] first_err_idx,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int AW = $clog2(p_num_msgs);
  localparam int CW = AW + 1;
  localparam int SW = (p_timeout > 1) ? $clog2(p_timeout) : 1;
  localparam logic [SW-1:0] STALL_LIM = SW'(p_timeout - 1);

  if (p_num_msgs < 2 || p_timeout < 1 || p_max_delay < 0) begin : g_bad_param
    $error("test_stream_sink: illegal parameter value");
  end

  // expected-message table (not reset)
  logic [p_msg_nbits-1:0] mem [p_num_msgs];

  always_ff @(posedge clk) begin
    if (load_en && (int'(load_addr) < p_num_msgs)) mem[load_addr] <= load_data;
  end

  sink_state_e   state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] stall_q;
  logic [CW-1:0] err_cnt_q;
  logic [AW-1:0] first_q;
  sink_flags_t   flags_q;

  logic          xfer, last, mismatch, stall_hit, start_go;
  logic [CW-1:0] cnt_clamp;

  assign xfer      = val && rdy;
  assign last      = ({1'b0, idx_q} == (cnt_q - 1'b1));
  assign mismatch  = xfer && (msg != mem[idx_q]);
  assign stall_hit = (state_q == RUN) && !xfer && (stall_q == STALL_LIM);
  assign start_go  = start && (state_q != RUN);
  assign cnt_clamp = (num_msgs > CW'(p_num_msgs)) ? CW'(p_num_msgs) : num_msgs;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = (num_msgs == '0) ? DONE : RUN;
      RUN:        if ((xfer && last) || stall_hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      stall_q   <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      flags_q   <= '0;
    end else if (start_go) begin
      // a start in DONE wins over a same-cycle val: the new run starts clean
      idx_q     <= '0;
      cnt_q     <= cnt_clamp;
      stall_q   <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      flags_q   <= '0;
    end else begin
      if (state_q == RUN) begin
        if (xfer) begin
          idx_q   <= idx_q + 1'b1;
          stall_q <= '0;
          if (mismatch) begin
            flags_q.error <= 1'b1;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            // err_count never returns to zero, so this marks the first miss
            if (err_cnt_q == '0) first_q <= idx_q;
          end
        end else if (stall_hit) begin
          flags_q.timeout <= 1'b1;
          flags_q.error   <= 1'b1;
        end else begin
          stall_q <= stall_q + 1'b1;
        end
      end
      if (state_q == DONE && val) begin
        flags_q.overrun <= 1'b1;
        flags_q.error   <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- rdy
`ifdef TEST_STREAM_SINK_RANDOM_DELAY_EN
  localparam int DW = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;

  logic [31:0]   lfsr_q;
  logic [DW-1:0] delay_q, delay_ld;

  test_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .load (1'b0),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign delay_ld = DW'(int'(lfsr_q[3:0]) % (p_max_delay + 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  delay_q <= '0;
    else if (start_go || xfer) delay_q <= delay_ld;
    else if (delay_q != '0)   delay_q <= delay_q - 1'b1;
  end

  assign rdy = (state_q == RUN) && (delay_q == '0);
`else
  assign rdy = (state_q == RUN);
`endif

  assign done          = (state_q == DONE);
  assign error         = flags_q.error;
  assign overrun       = flags_q.overrun;
  assign timeout       = flags_q.timeout;
  assign err_count     = err_cnt_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_test_stream_sink.sv
module tb_test_stream_sink;

  localparam int NB = 32;
  localparam int NM = 16;
  localparam int TO = 1000;
  localparam int AW = $clog2(NM);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [NB-1:0] load_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   num_msgs = '0;
  logic [NB-1:0] msg = '0;
  logic          val = 1'b0;
  logic          rdy, done, error, overrun, timeout;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_idx;

  int checks = 0;
  int errors = 0;
  int stalled_val = 0;

  logic [NB-1:0] tbl [NM];   // reference copy of the expected table
  bit   tracing = 0;
  bit   trace_q [$];

  test_stream_sink #(.p_msg_nbits(NB), .p_num_msgs(NM), .p_timeout(TO), .p_max_delay(7)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .num_msgs(num_msgs), .msg(msg), .val(val), .rdy(rdy), .done(done),
    .error(error), .err_count(err_count), .first_err_idx(first_err_idx),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tracing) trace_q.push_back(rdy);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [NB-1:0] d);
    load_en = 1'b1; load_addr = AW'(a); load_data = d; tbl[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic go(input int n);
    start = 1'b1; num_msgs = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // offer one message after 'gap' idle cycles; returns at the negedge after it is taken
  task automatic send(input logic [NB-1:0] m, input int gap);
    bit took = 0;
    val = 1'b0;
    repeat (gap) @(negedge clk);
    val = 1'b1; msg = m;
    for (int i = 0; i < 200 && !took; i++) begin
      took = rdy;
      if (!took) stalled_val++;
      @(negedge clk);
    end
    val = 1'b0;
    if (!took) chk("send_bound", 0, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, rdy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_errcnt"}, err_count, 0);
    chk({tag, "_first"}, first_err_idx, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    logic [NB-1:0] seq [4];
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    // 1: clean 4-message run with val held high
    load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
    go(4);
`ifndef TEST_STREAM_SINK_RANDOM_DELAY_EN
    chk("t1_rdy_run", rdy, 1);
`endif
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("t1_done_early", done, 0);
      send(tbl[i], 0);
    end
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t1_errcnt", err_count, 0);
    chk("t1_rdy_after", rdy, 0);

    // 2: overrun in DONE
    val = 1'b1; msg = 32'h66;
    @(negedge clk);
    val = 1'b0;
    chk("t2_overrun", overrun, 1);
    chk("t2_error", error, 1);
    chk("t2_errcnt", err_count, 0);

    // 3: two mismatches
    go(4);
    chk("t3_cleared", {overrun, error}, 0);
    seq = '{32'h11, 32'h99, 32'h33, 32'h55};
    for (int i = 0; i < 4; i++) send(seq[i], 0);
    chk("t3_errcnt", err_count, 2);
    chk("t3_first", first_err_idx, 1);
    chk("t3_error", error, 1);
    chk("t3_done", done, 1);

    // 4: stall timeout
    go(2);
    repeat (TO - 1) @(negedge clk);
    chk("t4_pre_timeout", {timeout, done}, 0);
    @(negedge clk);
    chk("t4_timeout", timeout, 1);
    chk("t4_done", done, 1);
    chk("t4_error", error, 1);
    chk("t4_rdy", rdy, 0);

    // 5: asynchronous reset mid-run, then replay on the preserved table
    go(4);
    send(32'h11, 0);
    send(32'h98, 0);
    chk("t5_error_set", error, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rdy", rdy, 0);
    chk("t5_done", done, 0);
    chk("t5_error", error, 0);
    chk("t5_errcnt", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    go(4);
    for (int i = 0; i < 4; i++) send(tbl[i], 0);
    chk("t5_done2", done, 1);
    chk("t5_clean", {error, err_count}, 0);

    // 6: randomized runs against a count-of-mismatches model
    for (int it = 0; it < 10; it++) begin
      int n, cnt, nerr, first;
      logic [NB-1:0] m;
      for (int a = 0; a < NM; a++) load(a, $urandom);
      n   = $urandom_range(0, NM + 6);
      cnt = (n > NM) ? NM : n;
      nerr = 0; first = 0;
      go(n);
      for (int i = 0; i < cnt; i++) begin
        m = tbl[i];
        if ($urandom_range(0, 3) == 0) m = m ^ (32'h1 << $urandom_range(0, 31));
        if (m != tbl[i]) begin
          if (nerr == 0) first = i;
          nerr++;
        end
        if (i == cnt - 1) chk($sformatf("r%0d_done_early", it), done, 0);
        send(m, $urandom_range(0, 3));
      end
      chk($sformatf("r%0d_done", it), done, 1);
      chk($sformatf("r%0d_errcnt", it), err_count, nerr);
      chk($sformatf("r%0d_first", it), first_err_idx, first);
      chk($sformatf("r%0d_error", it), error, nerr != 0);
      chk($sformatf("r%0d_flags", it), {overrun, timeout, rdy}, 0);
    end

`ifdef TEST_STREAM_SINK_RANDOM_DELAY_EN
    // 7: backpressure determinism, two identical runs from reset
    begin
      bit trace_a [$];
      for (int a = 0; a < 8; a++) load(a, 32'h100 + a);
      stalled_val = 0;
      for (int run = 0; run < 2; run++) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        trace_q.delete();
        tracing = 1;
        go(8);
        for (int i = 0; i < 8; i++) send(tbl[i], 0);
        tracing = 0;
        chk($sformatf("d%0d_done", run), done, 1);
        chk($sformatf("d%0d_errcnt", run), err_count, 0);
        if (run == 0) trace_a = trace_q;
      end
      chk("d_stalled", stalled_val > 0, 1);
      chk("d_trace_len", trace_q.size(), trace_a.size());
      chk("d_trace_same", trace_q == trace_a, 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
